// File: rtl/audio_dac_tx.sv
// I2S-style mono DAC transmitter: a small sample FIFO feeding a 16-bit MSB-first shifter.
// The shifter is timed from the codec's bclk/daclrck, which are synchronized into i_clk.
module audio_dac_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_bclk,
  input  logic        i_daclrck,
  input  logic        i_enable,
  input  logic        i_valid,
  input  logic [15:0] i_data,
  output logic        o_ready,
  output logic        o_dacdat,
  output logic        o_underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_MSB = 2'd1;
  localparam logic [1:0] ST_SHIFT    = 2'd2;
  localparam logic [1:0] ST_PAD      = 2'd3;

  // Bit 0/1 form the synchronizer, bit 2 is the previous value for edge detection.
  logic [2:0] bclk_sync_reg;
  logic [2:0] lrck_sync_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_sync_reg <= '0;
      lrck_sync_reg <= '0;
    end else begin
      bclk_sync_reg <= {bclk_sync_reg[1:0], i_bclk};
      lrck_sync_reg <= {lrck_sync_reg[1:0], i_daclrck};
    end
  end

  logic bclk_fall;
  logic lrck_edge;
  logic lrck_fall;
  logic lrck_rise;

  assign bclk_fall = bclk_sync_reg[2] & ~bclk_sync_reg[1];
  assign lrck_edge = lrck_sync_reg[2] ^ lrck_sync_reg[1];
  assign lrck_fall = lrck_sync_reg[2] & ~lrck_sync_reg[1];
  assign lrck_rise = ~lrck_sync_reg[2] & lrck_sync_reg[1];

  // Sample FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [15:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        fifo_full;
  logic        fifo_empty;
  logic        wr_en;
  logic        pop_en;
  logic        left_consumed_reg;

  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign o_ready    = ~fifo_full;
  assign wr_en      = i_valid & ~fifo_full;
  assign pop_en     = lrck_rise & left_consumed_reg;

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // The left slot decides what the whole frame carries; the right slot replays it.
  logic        left_take;
  logic [15:0] left_word;

  assign left_take = i_enable & ~fifo_empty;
  assign left_word = left_take ? fifo_mem[rd_ptr_reg[AW-1:0]] : 16'h0000;

  logic [1:0]  state_reg;
  logic [15:0] shift_reg;
  logic [15:0] held_reg;
  logic [4:0]  bit_cnt_reg;
  logic        dacdat_reg;
  logic        underrun_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg         <= ST_IDLE;
      shift_reg         <= '0;
      held_reg          <= '0;
      bit_cnt_reg       <= '0;
      dacdat_reg        <= 1'b0;
      underrun_reg      <= 1'b0;
      left_consumed_reg <= 1'b0;
    end else if (lrck_edge) begin
      // A slot boundary always wins, even over a coincident bclk edge or a word in flight.
      state_reg    <= ST_WAIT_MSB;
      bit_cnt_reg  <= '0;
      underrun_reg <= lrck_fall & fifo_empty;
      if (lrck_fall) begin
        shift_reg         <= left_word;
        held_reg          <= left_word;
        left_consumed_reg <= left_take;
      end else begin
        shift_reg         <= held_reg;
        left_consumed_reg <= 1'b0;
      end
    end else begin
      underrun_reg <= 1'b0;
      if (bclk_fall) begin
        case (state_reg)
          ST_WAIT_MSB: begin
            dacdat_reg  <= shift_reg[15];
            shift_reg   <= {shift_reg[14:0], 1'b0};
            bit_cnt_reg <= 5'd1;
            state_reg   <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (bit_cnt_reg == 5'd16) begin
              dacdat_reg <= 1'b0;
              state_reg  <= ST_PAD;
            end else begin
              dacdat_reg  <= shift_reg[15];
              shift_reg   <= {shift_reg[14:0], 1'b0};
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end
          ST_PAD: begin
            dacdat_reg <= 1'b0;
          end
          default: begin
            dacdat_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_dacdat   = dacdat_reg;
  assign o_underrun = underrun_reg;

endmodule

// File: tb/tb_audio_dac_tx.sv
// Randomized scoreboard bench for audio_dac_tx: a queue-based model predicts each slot's word
// and underrun, while independent monitors deserialize o_dacdat and count underrun pulses.
module tb_audio_dac_tx;
  localparam int DEPTH     = 4;
  localparam int HALF      = 5;
  localparam int SLOT_BCLK = 20;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_bclk;
  logic        i_daclrck;
  logic        i_enable;
  logic        i_valid;
  logic [15:0] i_data;
  logic        o_ready;
  logic        o_dacdat;
  logic        o_underrun;

  audio_dac_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_bclk     (i_bclk),
    .i_daclrck  (i_daclrck),
    .i_enable   (i_enable),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .o_dacdat   (o_dacdat),
    .o_underrun (o_underrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] model_q [$];
  logic [15:0] exp_q   [$];
  int          uexp_q  [$];
  logic [15:0] held;
  bit          consumed;
  bit          mon_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Simple write between frames: the model alone decides whether it is accepted.
  task automatic write_sample(input logic [15:0] d);
    bit acc;
    @(negedge i_clk);
    acc = (model_q.size() < DEPTH);
    check("o_ready before write", {31'd0, o_ready}, {31'd0, acc});
    if (acc) model_q.push_back(d);
    i_valid = 1'b1;
    i_data  = d;
    @(negedge i_clk);
    i_valid = 1'b0;
    $display("write %h accepted=%0d", d, acc);
  endtask

  // Handshake write held until the DUT is ready; used while pops are in flight.
  task automatic hs_write(input logic [15:0] d);
    bit done;
    done = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = d;
    for (int t = 0; t < 3000 && !done; t++) begin
      if (o_ready) begin
        model_q.push_back(d);
        done = 1'b1;
      end
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    check("handshake write completes", {31'd0, done}, 32'd1);
    $display("handshake write %h done=%0d", d, done);
  endtask

  task automatic run_slot(input bit left, input int nb);
    logic [15:0] tmp;
    int          uexp;
    @(negedge i_clk);
    if (left) begin
      uexp = (model_q.size() == 0) ? 1 : 0;
      if (i_enable && model_q.size() > 0) begin
        held     = model_q[0];
        consumed = 1'b1;
      end else begin
        held     = 16'h0000;
        consumed = 1'b0;
      end
      if (mon_en) begin
        exp_q.push_back(held);
        uexp_q.push_back(uexp);
      end
    end else begin
      if (mon_en) exp_q.push_back(held);
      if (consumed) tmp = model_q.pop_front();
      consumed = 1'b0;
    end
    i_daclrck = left ? 1'b0 : 1'b1;
    i_bclk    = 1'b0;
    repeat (HALF) @(negedge i_clk);
    for (int p = 1; p <= nb; p++) begin
      i_bclk = 1'b1;
      repeat (HALF) @(negedge i_clk);
      if (p < nb) begin
        i_bclk = 1'b0;
        repeat (HALF) @(negedge i_clk);
      end
    end
  endtask

  task automatic run_frame();
    run_slot(1'b1, SLOT_BCLK);
    run_slot(1'b0, SLOT_BCLK);
  endtask

  // Word monitor: MSB arrives at the 2nd bclk rise after the slot edge (one-bit delay).
  initial begin : word_mon
    logic [15:0] w;
    logic [15:0] e;
    logic        pad;
    forever begin
      @(i_daclrck);
      if (mon_en) begin
        w   = '0;
        pad = 1'b0;
        for (int k = 1; k <= 19; k++) begin
          @(posedge i_bclk);
          if (k >= 2 && k <= 17) w = {w[14:0], o_dacdat};
          else pad = pad | o_dacdat;
        end
        if (exp_q.size() == 0) begin
          check("unexpected slot word", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("slot word", {16'd0, w}, {16'd0, e});
        end
        check("pad bits zero", {31'd0, pad}, 32'd0);
        $display("slot lrck=%0d word %h", i_daclrck, w);
      end
    end
  end

  initial begin : underrun_mon
    int cnt;
    int ue;
    forever begin
      @(negedge i_daclrck);
      if (mon_en) begin
        cnt = 0;
        repeat (10) begin
          @(negedge i_clk);
          if (o_underrun) cnt++;
        end
        if (uexp_q.size() == 0) begin
          check("unexpected underrun window", 32'd1, 32'd0);
        end else begin
          ue = uexp_q.pop_front();
          check("underrun pulse cycles", cnt, ue);
        end
      end
    end
  end

  initial begin : main
    logic [15:0] d;
    mon_en    = 1'b0;
    held      = 16'h0000;
    consumed  = 1'b0;
    i_rst_n   = 1'b0;
    i_bclk    = 1'b1;
    i_daclrck = 1'b1;
    i_enable  = 1'b1;
    i_valid   = 1'b0;
    i_data    = '0;
    repeat (3) @(negedge i_clk);
    check("reset o_ready", {31'd0, o_ready}, 32'd1);
    check("reset o_dacdat", {31'd0, o_dacdat}, 32'd0);
    check("reset o_underrun", {31'd0, o_underrun}, 32'd0);
    i_rst_n = 1'b1;
    repeat (10) @(negedge i_clk);
    mon_en = 1'b1;

    // Single known word, then an empty frame.
    write_sample(16'hA5C3);
    run_frame();
    run_frame();

    // Overfill: fifth write dropped, four frames drain in order, then underrun.
    for (int i = 0; i < 5; i++) write_sample(16'h1111 * (i + 1));
    @(negedge i_clk);
    check("o_ready when full", {31'd0, o_ready}, 32'd0);
    for (int i = 0; i < 5; i++) run_frame();

    // Disabled output leaves the FIFO untouched.
    write_sample(16'h7FFF);
    i_enable = 1'b0;
    run_frame();
    i_enable = 1'b1;
    run_frame();

    // Pop while full with a write waiting on o_ready.
    for (int i = 0; i < DEPTH; i++) write_sample(16'($urandom));
    fork
      run_frame();
      hs_write(16'hBEEF);
    join
    @(negedge i_clk);
    check("o_ready after refill", {31'd0, o_ready}, 32'd0);

    // Randomized traffic.
    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) write_sample(16'($urandom));
      i_enable = ($urandom_range(0, 3) != 0);
      run_frame();
    end
    i_enable = 1'b1;
    while (model_q.size() > 0) run_frame();
    run_frame();

    // Reset while bit 7 of 16'h8001 is on the wire.
    write_sample(16'h8001);
    mon_en = 1'b0;
    @(negedge i_clk);
    i_daclrck = 1'b0;
    i_bclk    = 1'b0;
    repeat (HALF) @(negedge i_clk);
    for (int p = 1; p <= 10; p++) begin
      i_bclk = 1'b1;
      repeat (HALF) @(negedge i_clk);
      if (p < 10) begin
        i_bclk = 1'b0;
        repeat (HALF) @(negedge i_clk);
      end
    end
    i_rst_n = 1'b0;
    #1;
    check("o_dacdat in reset", {31'd0, o_dacdat}, 32'd0);
    check("o_ready in reset", {31'd0, o_ready}, 32'd1);
    model_q.delete();
    held     = 16'h0000;
    consumed = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    mon_en = 1'b1;
    run_slot(1'b0, SLOT_BCLK);
    run_frame();

    repeat (20) @(negedge i_clk);
    check("leftover expected words", exp_q.size(), 32'd0);
    check("leftover underrun checks", uexp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
